rca_pipeline_vr: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor with valid/ready flow control, bubble collapsing and asynchronous active-low reset. It is the successor of the fixed-latency `rippleCarryAdder_pipeline`. The `Nbits` datapath is split into `Nstages` equal carry-chain slices, one register stage per slice. It sits between producer and consumer blocks that may stall, and sustains one operation per cycle when unstalled.

---
 rtl/rca_pipeline_vr.sv | 130 +++++++++++++
 tb/tb_rca_pipeline_vr.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_pipeline_vr.sv
// Pipelined ripple-carry adder/subtractor with valid/ready flow control and bubble collapsing.
// Define RCA_PIPE_OVF_EN to register signed overflow with the last stage; otherwise ovf is tied 0.
module rca_pipeline_vr #(
  parameter int unsigned Nbits   = 8,
  parameter int unsigned Nstages = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Nbits-1:0] a,
  input  logic [Nbits-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Nbits-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned W = Nbits / Nstages;

  logic [Nstages-1:0] v;
  logic [Nstages-1:0] adv;
  logic [Nbits-1:0]   b_eff;

  assign b_eff = sub ? ~b : b;

  // adv[k] = !v[k] | adv[k+1] unrolled: a stage moves if the output drains or any stage at/after it is empty
  for (genvar k = 0; k < Nstages; k++) begin : g_adv
    assign adv[k] = out_ready | ~(&v[Nstages-1:k]);
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < Nstages; k++) begin : g_stage
    localparam int unsigned SW = (k + 1) * W;
    localparam int unsigned BW = Nbits - SW;

    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          c_in;
    logic          v_in;
    logic [W:0]    res;
    logic [SW-1:0] sum_d;
    logic [SW-1:0] sum_q;
    logic          c_q;
    logic          v_q;

    if (k == 0) begin : g_head
      assign op_a  = a[W-1:0];
      assign op_b  = b_eff[W-1:0];
      assign c_in  = sub | cin;
      assign v_in  = in_valid;
      assign sum_d = res[W-1:0];
    end else begin : g_body
      assign op_a  = g_stage[k-1].g_buf.a_q[W-1:0];
      assign op_b  = g_stage[k-1].g_buf.b_q[W-1:0];
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign sum_d = {res[W-1:0], g_stage[k-1].sum_q};
    end

    assign res = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, c_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv[k]) begin
        v_q   <= v_in;
        c_q   <= res[W];
        sum_q <= sum_d;
      end
    end

    assign v[k] = v_q;

    // Skew buffer holds only the operand slices still to be added downstream
    if (BW > 0) begin : g_buf
      logic [BW-1:0] a_d;
      logic [BW-1:0] b_d;
      logic [BW-1:0] a_q;
      logic [BW-1:0] b_q;

      if (k == 0) begin : g_src_in
        assign a_d = a[Nbits-1:W];
        assign b_d = b_eff[Nbits-1:W];
      end else begin : g_src_prev
        assign a_d = g_stage[k-1].g_buf.a_q[BW+W-1:W];
        assign b_d = g_stage[k-1].g_buf.b_q[BW+W-1:W];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[k]) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign out_valid = v[Nstages-1];
  assign sum       = g_stage[Nstages-1].sum_q;
  assign cout      = g_stage[Nstages-1].c_q;

`ifdef RCA_PIPE_OVF_EN
  // The top operand slice reaching the last stage carries the sign bits of A and B'
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv[Nstages-1]) begin
      ovf_q <= (g_stage[Nstages-1].op_a[W-1] == g_stage[Nstages-1].op_b[W-1]) &
               (g_stage[Nstages-1].res[W-1] != g_stage[Nstages-1].op_a[W-1]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_rca_pipeline_vr.sv
// Scoreboard bench for rca_pipeline_vr (Nbits=8, Nstages=2); expected results are
// pushed on acceptance and compared when the result handshakes out.
module tb_rca_pipeline_vr;

  localparam int unsigned NB = 8;
  localparam int unsigned NS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NB-1:0] a = '0;
  logic [NB-1:0] b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NB-1:0] sum;
  logic          cout;
  logic          ovf;

  always #5 clk = ~clk;

  rca_pipeline_vr #(.Nbits(NB), .Nstages(NS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  typedef struct packed {
    logic [NB-1:0] sum;
    logic          cout;
    logic          ovf;
  } res_t;

  typedef struct packed {
    logic [NB-1:0] x;
    logic [NB-1:0] y;
    logic          ci;
    logic          sb;
  } vec_t;

  res_t exp_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  vec_t vecs [8] = '{
    '{8'd200, 8'd100, 1'b0, 1'b0},
    '{8'd5,   8'd7,   1'b1, 1'b1},
    '{8'h7F,  8'h01,  1'b0, 1'b0},
    '{8'h80,  8'h01,  1'b0, 1'b1},
    '{8'hFF,  8'h00,  1'b1, 1'b0},
    '{8'h00,  8'h01,  1'b0, 1'b1},
    '{8'h80,  8'h80,  1'b0, 1'b0},
    '{8'h33,  8'h33,  1'b1, 1'b1}
  };

  // Reference: integer arithmetic, borrow-based cout for subtraction, signed range for overflow
  function automatic res_t model(input logic [NB-1:0] x, input logic [NB-1:0] y,
                                 input logic ci, input logic sb);
    res_t r;
    int   ux, uy, sx, sy, u, s;
    ux = int'(x);
    uy = int'(y);
    sx = ux >= (1 << (NB - 1)) ? ux - (1 << NB) : ux;
    sy = uy >= (1 << (NB - 1)) ? uy - (1 << NB) : uy;
    if (sb) begin
      u = ux - uy;
      s = sx - sy;
      r.cout = (ux >= uy);
    end else begin
      u = ux + uy + int'(ci);
      s = sx + sy + int'(ci);
      r.cout = (u >= (1 << NB));
    end
    r.sum = NB'(u);
    r.ovf = 1'b0;
`ifdef RCA_PIPE_OVF_EN
    r.ovf = (s > (1 << (NB - 1)) - 1) || (s < -(1 << (NB - 1)));
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t vv, input logic vld);
    a = vv.x;
    b = vv.y;
    cin = vv.ci;
    sub = vv.sb;
    in_valid = vld;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if ({sum, cout, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b want all 0", sum, cout, ovf);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    step();
  endtask

  task automatic test_single_ops();
    res_t e;
    int   lat;
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i], 1'b1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL single_accept[%0d]: got in_ready=%b want 1", i, in_ready);
      end
      exp_q.push_back(model(vecs[i].x, vecs[i].y, vecs[i].ci, vecs[i].sb));
      step();
      in_valid = 1'b0;
      lat = 1;
      #1;
      while (out_valid !== 1'b1 && lat < int'(NS) + 4) begin
        step();
        #1;
        lat++;
      end
      checks++;
      if (lat != int'(NS)) begin
        errors++;
        $display("FAIL single_latency[%0d]: got %0d edges want %0d", i, lat, NS);
      end
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if ({sum, cout, ovf} !== e) begin
          errors++;
          $display("FAIL single_result[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                   i, sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
      end else begin
        exp_q.delete();
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    res_t e;
    vec_t vv;
    int   idx = 0;
    int   got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vv = '{NB'(idx + 1), NB'(idx + 1), 1'b0, 1'b0};
      drive(vv, idx < 4);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(vv.x, vv.y, vv.ci, vv.sb));
        idx++;
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (idx != int'(NS) || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_fill: got accepts=%0d in_ready=%b want %0d/0", idx, in_ready, NS);
    end
    checks++;
    if (out_valid !== 1'b1 || exp_q.size() == 0 || sum !== exp_q[0].sum) begin
      errors++;
      $display("FAIL b2b_stalled_head: got out_valid=%b sum=%h want 1/%h", out_valid, sum, NB'(2));
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      vv = '{NB'(idx + 1), NB'(idx + 1), 1'b0, 1'b0};
      drive(vv, idx < 4);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_stream[%0d]: got out_valid=%b want 1", c, out_valid);
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({sum, cout, ovf} !== e || sum !== NB'(2 * (got + 1))) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got sum=%h cout=%b want sum=%h cout=%b",
                   got, sum, cout, NB'(2 * (got + 1)), e.cout);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(vv.x, vv.y, vv.ci, vv.sb));
        idx++;
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (got != 4 || exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: got %0d results pending=%0d out_valid=%b want 4/0/0",
               got, exp_q.size(), out_valid);
    end
    step();
  endtask

  task automatic test_bubble();
    res_t e;
    vec_t v1 = '{8'd10, 8'd20, 1'b0, 1'b0};
    vec_t v2 = '{8'd30, 8'd40, 1'b1, 1'b0};
    int   got = 0;
    out_ready = 1'b0;
    drive(v1, 1'b1);
    #1;
    if (in_ready) exp_q.push_back(model(v1.x, v1.y, v1.ci, v1.sb));
    step();
    in_valid = 1'b0;
    step();
    drive(v2, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bubble_accept: got in_ready=%b out_valid=%b want 1/1", in_ready, out_valid);
    end
    if (in_ready) exp_q.push_back(model(v2.x, v2.y, v2.ci, v2.sb));
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || exp_q.size() != 2) begin
      errors++;
      $display("FAIL bubble_full: got in_ready=%b held=%0d want 0/2", in_ready, exp_q.size());
    end
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bubble_extra: got sum=%h want no result", sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, cout, ovf} !== e) begin
            errors++;
            $display("FAIL bubble_result[%0d]: got sum=%h cout=%b want sum=%h cout=%b",
                     got, sum, cout, e.sum, e.cout);
          end
          got++;
        end
      end
      step();
    end
    checks++;
    if (got != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bubble_count: got %0d results want 2", got);
    end
  endtask

  task automatic test_random();
    res_t e;
    res_t held = '0;
    logic stalled = 1'b0;
    vec_t vv;
    for (int c = 0; c < 320; c++) begin
      vv = '{NB'($urandom), NB'($urandom), 1'($urandom), 1'($urandom)};
      drive(vv, (c < 300) && ($urandom_range(3, 0) != 0));
      out_ready = (c >= 300) || ($urandom_range(2, 0) != 0);
      #1;
      checks++;
      if (in_ready !== (out_ready || exp_q.size() < NS)) begin
        errors++;
        $display("FAIL rand_in_ready[%0d]: got %b want %b", c, in_ready, out_ready || exp_q.size() < NS);
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || {sum, cout, ovf} !== held) begin
          errors++;
          $display("FAIL rand_stall_hold[%0d]: got v=%b sum=%h want 1/%h", c, out_valid, sum, held.sum);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra[%0d]: got sum=%h want no result", c, sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, cout, ovf} !== e) begin
            errors++;
            $display("FAIL rand_result[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     c, sum, cout, ovf, e.sum, e.cout, e.ovf);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(vv.x, vv.y, vv.ci, vv.sb));
      stalled = out_valid && !out_ready;
      held = {sum, cout, ovf};
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d results outstanding want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_async_reset();
    vec_t v1 = '{8'hF0, 8'h20, 1'b0, 1'b0};
    vec_t v2 = '{8'h7F, 8'h01, 1'b0, 1'b0};
    out_ready = 1'b0;
    drive(v1, 1'b1);
    step();
    drive(v2, 1'b1);
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL areset_prefill: got out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, sum, cout, ovf} !== '0) begin
      errors++;
      $display("FAIL areset_immediate: got v=%b sum=%h cout=%b ovf=%b want all 0",
               out_valid, sum, cout, ovf);
    end
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL areset_stale[%0d]: got out_valid=%b in_ready=%b want 0/1", c, out_valid, in_ready);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_back_to_back();
    test_bubble();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout want completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
